// File: rtl/prf_ready_checkpointed_if.sv
`default_nettype none
// ============================================================================
//  Module      : prf_ready_checkpointed_if
//  Description : Bus bundle for the checkpointed physical register file.
//                Carries the read ports (tag in, data/ready out), writeback
//                ports, rename allocation ports, checkpoint save/restore
//                controls, and the registered wakeup / ready-table outputs.
//                master = pipeline side, slave = register file.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prf_ready_checkpointed_if #(
    parameter int NUM_PREGS = 128,
    parameter int DATA_W    = 32,
    parameter int NUM_WR    = 3,
    parameter int NUM_RD    = 6,
    parameter int NUM_ALLOC = 1,
    parameter int NUM_CKPT  = 4
) ();
    localparam int PTAG_W = $clog2(NUM_PREGS);
    localparam int CKPT_W = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

    logic [NUM_RD*PTAG_W-1:0]    rd_tag;
    logic [NUM_RD*DATA_W-1:0]    rd_data;
    logic [NUM_RD-1:0]           rd_rdy;
    logic [NUM_WR-1:0]           wr_en;
    logic [NUM_WR*PTAG_W-1:0]    wr_tag;
    logic [NUM_WR*DATA_W-1:0]    wr_data;
    logic [NUM_ALLOC-1:0]        alloc_en;
    logic [NUM_ALLOC*PTAG_W-1:0] alloc_tag;
    logic                        ckpt_save;
    logic [CKPT_W-1:0]           ckpt_id;
    logic                        ckpt_restore;
    logic [CKPT_W-1:0]           restore_id;
    logic [NUM_WR-1:0]           wake_valid;
    logic [NUM_WR*PTAG_W-1:0]    wake_tag;
    logic [NUM_PREGS-1:0]        rdy_vec;
    logic                        wr_conflict;

    modport master (
        output rd_tag, wr_en, wr_tag, wr_data, alloc_en, alloc_tag,
               ckpt_save, ckpt_id, ckpt_restore, restore_id,
        input  rd_data, rd_rdy, wake_valid, wake_tag, rdy_vec, wr_conflict
    );

    modport slave (
        input  rd_tag, wr_en, wr_tag, wr_data, alloc_en, alloc_tag,
               ckpt_save, ckpt_id, ckpt_restore, restore_id,
        output rd_data, rd_rdy, wake_valid, wake_tag, rdy_vec, wr_conflict
    );
endinterface
`default_nettype wire

// File: rtl/prf_ready_checkpointed.sv
`default_nettype none
// ============================================================================
//  Module      : prf_ready_checkpointed
//  Description : Physical register file with a per-register ready table and
//                NUM_CKPT ready-table checkpoints for mispredict recovery.
//  Ports       : clk   - clock
//                reset - synchronous, active-low reset
//                bus   - slave modport: read ports (combinational, write-
//                        bypassed), writeback ports, allocation ports,
//                        checkpoint save/restore, registered wakeup,
//                        registered live ready table, sticky wr_conflict.
//  Revision    : 1.0 - initial release
// ============================================================================
module prf_ready_checkpointed #(
    parameter int NUM_PREGS = 128,
    parameter int DATA_W    = 32,
    parameter int NUM_WR    = 3,
    parameter int NUM_RD    = 6,
    parameter int NUM_ALLOC = 1,
    parameter int NUM_CKPT  = 4
) (
    input  wire logic               clk,
    input  wire logic               reset,
    prf_ready_checkpointed_if.slave bus
);
    localparam int PTAG_W = $clog2(NUM_PREGS);
    localparam int CKPT_W = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]        mem_q  [NUM_PREGS];
    logic [DATA_W-1:0]        mem_d  [NUM_PREGS];
    logic [NUM_PREGS-1:0]     live_q;
    logic [NUM_PREGS-1:0]     live_d;
    logic [NUM_PREGS-1:0]     ckpt_q [NUM_CKPT];
    logic [NUM_PREGS-1:0]     ckpt_d [NUM_CKPT];
    logic [NUM_WR-1:0]        wake_valid_q;
    logic [NUM_WR-1:0]        wake_valid_d;
    logic [NUM_WR*PTAG_W-1:0] wake_tag_q;
    logic [NUM_WR*PTAG_W-1:0] wake_tag_d;
    logic                     wr_conflict_q;
    logic                     wr_conflict_d;

    // ------------------------------------------------------------------
    // Write / alloc decode
    // ------------------------------------------------------------------
    logic [NUM_WR-1:0]    wr_hit;     // valid write to a real (nonzero) tag
    logic [NUM_PREGS-1:0] wr_set;     // registers made ready this cycle
    logic [NUM_PREGS-1:0] alloc_clr;  // registers made not-ready this cycle

    generate
        for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_hit
            assign wr_hit[j] = bus.wr_en[j] && (bus.wr_tag[j*PTAG_W +: PTAG_W] != '0);
        end
    endgenerate

    always_comb begin
        wr_set = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_hit[j]) begin
                wr_set[bus.wr_tag[j*PTAG_W +: PTAG_W]] = 1'b1;
            end
        end
    end

    // Allocation is dropped on a restore cycle: the allocating instruction
    // belongs to the squashed path.
    always_comb begin
        alloc_clr = '0;
        for (int k = 0; k < NUM_ALLOC; k++) begin
            if (bus.alloc_en[k] && !bus.ckpt_restore &&
                (bus.alloc_tag[k*PTAG_W +: PTAG_W] != '0)) begin
                alloc_clr[bus.alloc_tag[k*PTAG_W +: PTAG_W]] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state: live table, checkpoints, data array
    // ------------------------------------------------------------------
    always_comb begin
        if (bus.ckpt_restore) begin
            live_d = ckpt_q[bus.restore_id] | wr_set;
        end else begin
            // Write applied after alloc so a same-cycle write wins.
            live_d = (live_q & ~alloc_clr) | wr_set;
        end
        live_d[0] = 1'b1;
    end

    // Stored checkpoints absorb every writeback so that a later restore
    // never un-readies a register that has already completed.
    always_comb begin
        for (int s = 0; s < NUM_CKPT; s++) begin
            if (bus.ckpt_save && (bus.ckpt_id == CKPT_W'(s))) begin
                ckpt_d[s] = live_d;
            end else begin
                ckpt_d[s] = ckpt_q[s] | wr_set;
            end
        end
    end

    // Ascending port order: the highest-indexed port to the same tag wins.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_hit[j]) begin
                mem_d[bus.wr_tag[j*PTAG_W +: PTAG_W]] = bus.wr_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Wakeup broadcast and write-conflict detection
    // ------------------------------------------------------------------
    always_comb begin
        wake_tag_d = wake_tag_q;
        for (int j = 0; j < NUM_WR; j++) begin
            wake_valid_d[j] = wr_hit[j];
            if (wr_hit[j]) begin
                wake_tag_d[j*PTAG_W +: PTAG_W] = bus.wr_tag[j*PTAG_W +: PTAG_W];
            end
        end
    end

    always_comb begin
        wr_conflict_d = wr_conflict_q;
        for (int a = 0; a < NUM_WR; a++) begin
            for (int b = a + 1; b < NUM_WR; b++) begin
                if (wr_hit[a] && wr_hit[b] &&
                    (bus.wr_tag[a*PTAG_W +: PTAG_W] == bus.wr_tag[b*PTAG_W +: PTAG_W])) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                mem_q[i] <= '0;
            end
            for (int s = 0; s < NUM_CKPT; s++) begin
                ckpt_q[s] <= '1;
            end
            live_q        <= '1;
            wake_valid_q  <= '0;
            wake_tag_q    <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            ckpt_q        <= ckpt_d;
            live_q        <= live_d;
            wake_valid_q  <= wake_valid_d;
            wake_tag_q    <= wake_tag_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read ports with same-cycle write bypass.
    // A same-cycle alloc is deliberately not visible here.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_data_w [NUM_RD];
    logic [NUM_RD-1:0] rd_rdy_w;

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            if (bus.rd_tag[i*PTAG_W +: PTAG_W] == '0) begin
                rd_data_w[i] = '0;
                rd_rdy_w[i]  = 1'b1;
            end else begin
                rd_data_w[i] = mem_q[bus.rd_tag[i*PTAG_W +: PTAG_W]];
                rd_rdy_w[i]  = live_q[bus.rd_tag[i*PTAG_W +: PTAG_W]];
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_hit[j] &&
                        (bus.wr_tag[j*PTAG_W +: PTAG_W] == bus.rd_tag[i*PTAG_W +: PTAG_W])) begin
                        rd_data_w[i] = bus.wr_data[j*DATA_W +: DATA_W];
                        rd_rdy_w[i]  = 1'b1;
                    end
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            assign bus.rd_data[i*DATA_W +: DATA_W] = rd_data_w[i];
        end
    endgenerate

    assign bus.rd_rdy      = rd_rdy_w;
    assign bus.wake_valid  = wake_valid_q;
    assign bus.wake_tag    = wake_tag_q;
    assign bus.rdy_vec     = live_q;
    assign bus.wr_conflict = wr_conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_prf_ready_checkpointed.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prf_ready_checkpointed
//  Description : Self-checking bench for prf_ready_checkpointed. Directed
//                scenarios plus randomized traffic, compared every cycle
//                against a behavioural model held in plain arrays.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prf_ready_checkpointed;
    localparam int NP = 128;
    localparam int DW = 32;
    localparam int NW = 3;
    localparam int NR = 6;
    localparam int NA = 1;
    localparam int NC = 4;
    localparam int PW = 7;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    prf_ready_checkpointed_if #(.NUM_PREGS(NP), .DATA_W(DW), .NUM_WR(NW),
        .NUM_RD(NR), .NUM_ALLOC(NA), .NUM_CKPT(NC)) bus ();

    prf_ready_checkpointed #(.NUM_PREGS(NP), .DATA_W(DW), .NUM_WR(NW),
        .NUM_RD(NR), .NUM_ALLOC(NA), .NUM_CKPT(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model
    logic [DW-1:0]    m_data [NP];
    logic [NP-1:0]    m_rdy;
    logic [NP-1:0]    m_ckpt [NC];
    logic [NW-1:0]    m_wv;
    logic [NW*PW-1:0] m_wt;
    logic             m_conf;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] wtag(input int j);
        return bus.wr_tag[j*PW +: PW];
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [PW-1:0] t);
        logic [DW-1:0] d;
        d = (t == 0) ? '0 : m_data[t];
        for (int j = 0; j < NW; j++)
            if (t != 0 && bus.wr_en[j] && wtag(j) == t) d = bus.wr_data[j*DW +: DW];
        return d;
    endfunction

    function automatic logic exp_rdy(input logic [PW-1:0] t);
        logic r;
        r = (t == 0) ? 1'b1 : m_rdy[t];
        for (int j = 0; j < NW; j++)
            if (t != 0 && bus.wr_en[j] && wtag(j) == t) r = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_data[i] = '0;
        for (int s = 0; s < NC; s++) m_ckpt[s] = '1;
        m_rdy  = '1;
        m_wv   = '0;
        m_wt   = '0;
        m_conf = 1'b0;
    endtask

    task automatic model_update();
        logic [NP-1:0] wmask;
        int hits [NP];
        wmask = '0;
        for (int i = 0; i < NP; i++) hits[i] = 0;
        for (int j = 0; j < NW; j++) begin
            m_wv[j] = bus.wr_en[j] && wtag(j) != 0;
            if (m_wv[j]) begin
                m_data[wtag(j)] = bus.wr_data[j*DW +: DW];
                wmask[wtag(j)]  = 1'b1;
                hits[wtag(j)]++;
                m_wt[j*PW +: PW] = wtag(j);
            end
        end
        for (int i = 0; i < NP; i++) if (hits[i] > 1) m_conf = 1'b1;
        if (bus.ckpt_restore) begin
            m_rdy = m_ckpt[bus.restore_id] | wmask;
        end else begin
            for (int k = 0; k < NA; k++)
                if (bus.alloc_en[k] && bus.alloc_tag[k*PW +: PW] != 0)
                    m_rdy[bus.alloc_tag[k*PW +: PW]] = 1'b0;
            m_rdy = m_rdy | wmask;
        end
        for (int s = 0; s < NC; s++) begin
            if (bus.ckpt_save && int'(bus.ckpt_id) == s) m_ckpt[s] = m_rdy;
            else m_ckpt[s] = m_ckpt[s] | wmask;
        end
    endtask

    task automatic compare_all();
        chk("rdy_vec", bus.rdy_vec, m_rdy);
        chk("wake_valid", 128'(bus.wake_valid), 128'(m_wv));
        chk("wake_tag", 128'(bus.wake_tag), 128'(m_wt));
        chk("wr_conflict", 128'(bus.wr_conflict), 128'(m_conf));
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("rd_data[%0d]", i), 128'(bus.rd_data[i*DW +: DW]),
                128'(exp_data(bus.rd_tag[i*PW +: PW])));
            chk($sformatf("rd_rdy[%0d]", i), 128'(bus.rd_rdy[i]),
                128'(exp_rdy(bus.rd_tag[i*PW +: PW])));
        end
    endtask

    // Inputs are driven just after negedge; outputs checked 1ns later,
    // then the model advances at the posedge.
    task automatic step();
        #1 compare_all();
        @(posedge clk);
        if (!reset) model_reset();
        else model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.wr_en        = '0;
        bus.wr_tag       = '0;
        bus.wr_data      = '0;
        bus.alloc_en     = '0;
        bus.alloc_tag    = '0;
        bus.ckpt_save    = 1'b0;
        bus.ckpt_id      = '0;
        bus.ckpt_restore = 1'b0;
        bus.restore_id   = '0;
    endtask

    task automatic set_wr(input int j, input int tag, input logic [DW-1:0] data);
        bus.wr_en[j]             = 1'b1;
        bus.wr_tag[j*PW +: PW]   = PW'(tag);
        bus.wr_data[j*DW +: DW]  = data;
    endtask

    task automatic set_alloc(input int tag);
        bus.alloc_en[0]     = 1'b1;
        bus.alloc_tag[0 +: PW] = PW'(tag);
    endtask

    function automatic int rnd_tag();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NP-1))
                                           : int'($urandom_range(0, 15));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle();
        bus.rd_tag = '0;
        reset = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // 1. Reset state
        for (int i = 0; i < NR; i++) bus.rd_tag[i*PW +: PW] = PW'(i + 1);
        #1;
        chk("reset_rdy_vec", bus.rdy_vec, {NP{1'b1}});
        for (int i = 0; i < NR; i++)
            chk("reset_rd_data", 128'(bus.rd_data[i*DW +: DW]), 128'(0));
        chk("reset_wake_valid", 128'(bus.wake_valid), 128'(0));
        chk("reset_wr_conflict", 128'(bus.wr_conflict), 128'(0));
        step();

        // 2. Alloc then write with bypass and wakeup
        idle(); set_alloc(5); step();
        idle(); bus.rd_tag[0 +: PW] = 7'd5;
        #1 chk("alloc_rdy0", 128'(bus.rd_rdy[0]), 128'(0));
        set_wr(1, 5, 32'hDEADBEEF);
        #1 chk("bypass_data", 128'(bus.rd_data[0 +: DW]), 128'h0DEADBEEF);
        chk("bypass_rdy", 128'(bus.rd_rdy[0]), 128'(1));
        step();
        idle();
        #1 chk("wake_valid_p1", 128'(bus.wake_valid), 128'(3'b010));
        chk("wake_tag_p1", 128'(bus.wake_tag[PW +: PW]), 128'(5));
        step();

        // 3. Checkpoint folding of a later write
        idle(); set_alloc(9); step();
        idle(); bus.ckpt_save = 1'b1; bus.ckpt_id = 2'd2; step();
        idle(); set_alloc(10); step();
        idle(); set_wr(0, 9, 32'd7); step();
        idle(); bus.ckpt_restore = 1'b1; bus.restore_id = 2'd2;
        bus.rd_tag[0 +: PW] = 7'd9; bus.rd_tag[PW +: PW] = 7'd10; step();
        idle();
        #1 chk("restore_p9_rdy", 128'(bus.rdy_vec[9]), 128'(1));
        chk("restore_p10_rdy", 128'(bus.rdy_vec[10]), 128'(1));
        chk("restore_p9_data", 128'(bus.rd_data[0 +: DW]), 128'(7));
        step();

        // 4. Restore with same-cycle write; alloc ignored
        idle(); set_alloc(20); step();
        idle(); bus.ckpt_save = 1'b1; bus.ckpt_id = 2'd1; step();
        idle(); bus.ckpt_restore = 1'b1; bus.restore_id = 2'd1;
        set_wr(2, 20, 32'h55); set_alloc(21); step();
        idle();
        #1 chk("restore_wr_p20", 128'(bus.rdy_vec[20]), 128'(1));
        chk("restore_alloc_p21", 128'(bus.rdy_vec[21]), 128'(1));
        step();

        // 5. Write-write conflict
        idle(); set_wr(0, 33, 32'h1); set_wr(2, 33, 32'h2);
        bus.rd_tag[0 +: PW] = 7'd33;
        #1 chk("ww_bypass", 128'(bus.rd_data[0 +: DW]), 128'(2));
        step();
        idle();
        #1 chk("ww_data", 128'(bus.rd_data[0 +: DW]), 128'(2));
        chk("ww_conflict", 128'(bus.wr_conflict), 128'(1));
        for (int c = 0; c < 3; c++) step();
        #1 chk("ww_conflict_sticky", 128'(bus.wr_conflict), 128'(1));

        // Randomized traffic, with one reset in the middle
        for (int c = 0; c < 400; c++) begin
            idle();
            reset = (c == 200) ? 1'b0 : 1'b1;
            for (int j = 0; j < NW; j++)
                if ($urandom_range(0, 1) == 1) set_wr(j, rnd_tag(), $urandom);
            if ($urandom_range(0, 1) == 1) set_alloc(rnd_tag());
            bus.ckpt_save    = ($urandom_range(0, 3) == 0);
            bus.ckpt_id      = 2'($urandom_range(0, NC-1));
            bus.ckpt_restore = ($urandom_range(0, 5) == 0);
            bus.restore_id   = 2'($urandom_range(0, NC-1));
            for (int i = 0; i < NR; i++) bus.rd_tag[i*PW +: PW] = PW'(rnd_tag());
            step();
        end
        reset = 1'b1;

        // 6. Tag 0 is inert; reset during a restore
        idle(); set_wr(0, 0, 32'hFFFF); set_alloc(0);
        bus.rd_tag[0 +: PW] = 7'd0;
        #1 chk("p0_data", 128'(bus.rd_data[0 +: DW]), 128'(0));
        chk("p0_rdy", 128'(bus.rd_rdy[0]), 128'(1));
        step();
        idle();
        #1 chk("p0_wake", 128'(bus.wake_valid), 128'(0));
        step();
        idle(); set_alloc(40); step();
        idle(); bus.ckpt_restore = 1'b1; bus.restore_id = 2'd3; reset = 1'b0; step();
        reset = 1'b1; idle();
        #1 chk("post_reset_rdy_vec", bus.rdy_vec, {NP{1'b1}});
        chk("post_reset_conflict", 128'(bus.wr_conflict), 128'(0));
        chk("post_reset_wake", 128'(bus.wake_valid), 128'(0));
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire
